// File: rtl/subservient_dbg_pkg.sv
// Constants shared by the subservient serial debug transmitter and receiver:
// frame geometry, field widths and the link FSM state encoding.
package subservient_dbg_pkg;

   localparam int FRAME_LEN = 64;
   localparam int ADR_W     = 32;
   localparam int DAT_W     = 32;
   localparam int BIT_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } dbg_state_e;

   // Address occupies the low half so it leaves the shift register first.
   function automatic logic [FRAME_LEN-1:0] frame_pack(input logic [ADR_W-1:0] adr,
                                                       input logic [DAT_W-1:0] dat);
      return {dat, adr};
   endfunction

endpackage

// File: rtl/subservient_dbg_tx_div.sv
// Bit-period divider: tick marks the last cycle of each BIT_DIV-cycle bit period
// and the count restarts whenever a new frame starts.
module subservient_dbg_tx_div #(
   parameter int BIT_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic en,
   output logic tick
);

   localparam int               DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

   logic [DIV_W-1:0] div_cnt_r;

   // Position of the current cycle inside its bit period
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt_r <= '0;
      end else if (start) begin
         div_cnt_r <= '0;
      end else if (en) begin
         if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end
      end else begin
         div_cnt_r <= '0;
      end
   end

   assign tick = (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/subservient_dbg_tx.sv
// Serialises a 32-bit address / 32-bit data write command into the 64-bit
// bit-serial frame consumed by the SoC debug receiver.
module subservient_dbg_tx
   import subservient_dbg_pkg::*;
#(
   parameter int BIT_DIV = 1,
   parameter int GAP     = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [ADR_W-1:0] i_cmd_adr,
   input  logic [DAT_W-1:0] i_cmd_dat,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   output logic             o_dbg_data,
   output logic             o_dbg_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_LEN - 1);
   localparam logic [7:0]           GAP_LAST = 8'(GAP - 1);

   dbg_state_e             state_r, state_s;
   logic [FRAME_LEN-1:0]   shreg_r, shreg_s;
   logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
   logic [7:0]             gap_cnt_r, gap_cnt_s;
   logic                   cmd_ready_r, busy_r, dbg_data_r, dbg_valid_r, done_r;
   logic                   dbg_data_s, dbg_valid_s, done_s;
   logic                   accept_s, shift_s, tick_s;

   assign accept_s = i_cmd_valid & cmd_ready_r;
   assign shift_s  = (state_r == ST_SHIFT);

   subservient_dbg_tx_div #(
      .BIT_DIV (BIT_DIV)
   ) u_div (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .start (accept_s),
      .en    (shift_s),
      .tick  (tick_s)
   );

   // Next state, datapath and next values of the registered outputs.
   // Output registers carry the value for the following cycle, so the first bit
   // is presented straight from the command inputs on the accepting edge.
   always_comb begin
      state_s     = state_r;
      shreg_s     = shreg_r;
      bit_cnt_s   = bit_cnt_r;
      gap_cnt_s   = gap_cnt_r;
      dbg_data_s  = 1'b0;
      dbg_valid_s = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s     = ST_SHIFT;
               shreg_s     = frame_pack(i_cmd_adr, i_cmd_dat);
               bit_cnt_s   = '0;
               dbg_data_s  = i_cmd_adr[0];
               dbg_valid_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (tick_s) begin
               if (bit_cnt_r == BIT_LAST) begin
                  done_s    = 1'b1;
                  gap_cnt_s = '0;
                  if (GAP == 0) begin
                     state_s = ST_IDLE;
                  end else begin
                     state_s = ST_GAP;
                  end
               end else begin
                  shreg_s     = {1'b0, shreg_r[FRAME_LEN-1:1]};
                  bit_cnt_s   = bit_cnt_r + BIT_CNT_W'(1);
                  dbg_data_s  = shreg_r[1];
                  dbg_valid_s = 1'b1;
               end
            end else begin
               dbg_data_s = shreg_r[0];
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
               state_s = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r     <= ST_IDLE;
         shreg_r     <= '0;
         bit_cnt_r   <= '0;
         gap_cnt_r   <= '0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         dbg_data_r  <= 1'b0;
         dbg_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         shreg_r     <= shreg_s;
         bit_cnt_r   <= bit_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
         cmd_ready_r <= (state_s == ST_IDLE);
         busy_r      <= (state_s != ST_IDLE);
         dbg_data_r  <= dbg_data_s;
         dbg_valid_r <= dbg_valid_s;
         done_r      <= done_s;
      end
   end

   assign o_cmd_ready = cmd_ready_r;
   assign o_busy      = busy_r;
   assign o_dbg_data  = dbg_data_r;
   assign o_dbg_valid = dbg_valid_r;
   assign o_done      = done_r;

endmodule

// File: tb/tb_subservient_dbg_tx.sv
// Bench for subservient_dbg_tx: three instances (BIT_DIV/GAP = 1/2, 4/3, 1/0) checked
// cycle by cycle against a timeline model plus a receiver that decodes the strobes.
module tb_subservient_dbg_tx;
   import subservient_dbg_pkg::*;

   localparam int ND   = 3;
   localparam int BD_A = 1;
   localparam int GP_A = 2;
   localparam int BD_B = 4;
   localparam int GP_B = 3;
   localparam int BD_C = 1;
   localparam int GP_C = 0;

   typedef struct {
      int          d;
      logic [31:0] adr;
      logic [31:0] dat;
      int          exp_done;
   } vec_t;

   typedef struct {
      int acc_cyc;
      int first_s;
      int last_s;
      int done_c;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   adr_in [ND];
   logic [31:0]   dat_in [ND];
   logic [ND-1:0] vld_in;
   logic [ND-1:0] ready_o, data_o, valid_o, busy_o, done_o;
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   subservient_dbg_tx #(.BIT_DIV(BD_A), .GAP(GP_A)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_adr(adr_in[0]), .i_cmd_dat(dat_in[0]),
      .i_cmd_valid(vld_in[0]), .o_cmd_ready(ready_o[0]), .o_dbg_data(data_o[0]),
      .o_dbg_valid(valid_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]));

   subservient_dbg_tx #(.BIT_DIV(BD_B), .GAP(GP_B)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_adr(adr_in[1]), .i_cmd_dat(dat_in[1]),
      .i_cmd_valid(vld_in[1]), .o_cmd_ready(ready_o[1]), .o_dbg_data(data_o[1]),
      .o_dbg_valid(valid_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]));

   subservient_dbg_tx #(.BIT_DIV(BD_C), .GAP(GP_C)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_adr(adr_in[2]), .i_cmd_dat(dat_in[2]),
      .i_cmd_valid(vld_in[2]), .o_cmd_ready(ready_o[2]), .o_dbg_data(data_o[2]),
      .o_dbg_valid(valid_o[2]), .o_busy(busy_o[2]), .o_done(done_o[2]));

   function automatic int bd_of(input int d);
      case (d)
         0:       return BD_A;
         1:       return BD_B;
         default: return BD_C;
      endcase
   endfunction

   function automatic int gap_of(input int d);
      case (d)
         0:       return GP_A;
         1:       return GP_B;
         default: return GP_C;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered on a negedge with instance d idle. Offers the command, then follows the
   // frame, the gap and the first idle cycle, leaving the next command (if any) on the bus.
   task automatic send_frame(input int d, input logic [31:0] adr, input logic [31:0] dat,
                             input bit nxt_vld, input logic [31:0] nxt_adr,
                             input logic [31:0] nxt_dat, output res_t r);
      int          bd, gp, flen, waited, strobes, k;
      logic [63:0] frame, rx;
      logic [4:0]  exp, act;
      bd = bd_of(d);
      gp = gap_of(d);
      flen = 64 * bd;
      frame = {dat, adr};
      rx = '0;
      strobes = 0;
      r = '{-1, -1, -1, -1};
      adr_in[d] = adr;
      dat_in[d] = dat;
      vld_in[d] = 1'b1;
      waited = 0;
      while (!ready_o[d] && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("accept_wait_d%0d", d), 64'(waited), 64'd0);
      if (!ready_o[d]) begin
         vld_in[d] = 1'b0;
         return;
      end
      r.acc_cyc = cyc;
      for (int c = 1; c <= flen + gp + 1; c++) begin
         @(negedge clk);
         if (c == 1 && nxt_vld) begin
            adr_in[d] = nxt_adr;
            dat_in[d] = nxt_dat;
         end else if (!nxt_vld) begin
            vld_in[d] = 1'b0;
            adr_in[d] = $urandom;
            dat_in[d] = $urandom;
         end
         k = c - 1;
         // {valid, data, done, busy, ready}
         if (k < flen)
            exp = {((k % bd) == 0), frame[k / bd], 1'b0, 1'b1, 1'b0};
         else if (c == flen + 1)
            exp = {1'b0, 1'b0, 1'b1, (gp > 0), (gp == 0)};
         else if (c <= flen + gp)
            exp = 5'b00010;
         else
            exp = 5'b00001;
         act = {valid_o[d], data_o[d], done_o[d], busy_o[d], ready_o[d]};
         check($sformatf("d%0d_c%0d_vld_dat_done_busy_rdy", d, c), 64'(act), 64'(exp));
         if (valid_o[d]) begin
            if (strobes < 64) rx[strobes] = data_o[d];
            strobes++;
            if (r.first_s < 0) r.first_s = cyc;
            r.last_s = cyc;
         end
         if (done_o[d]) r.done_c = cyc;
      end
      check($sformatf("strobe_count_d%0d", d), 64'(strobes), 64'd64);
      check($sformatf("rx_adr_d%0d", d), 64'(rx[31:0]), 64'(adr));
      check($sformatf("rx_dat_d%0d", d), 64'(rx[63:32]), 64'(dat));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs [5];
      res_t        r, r1, r2;
      int          d_rand, quiet;
      bit          hold;
      logic [31:0] ra, rd, na, nd;

      vecs[0] = '{0, 32'h0000_0004, 32'hA5A5_A5A5, 65};
      vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 257};
      vecs[2] = '{0, 32'h0000_0100, 32'hDEAD_BEEF, 65};
      vecs[3] = '{2, 32'h0000_0000, 32'hFFFF_FFFF, 65};
      vecs[4] = '{1, 32'h8000_0001, 32'h8000_0000, 257};

      rst_n = 1'b0;
      vld_in = '0;
      for (int i = 0; i < ND; i++) begin
         adr_in[i] = '0;
         dat_in[i] = '0;
      end
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < ND; i++)
            check($sformatf("reset_outs_d%0d", i),
                  64'({valid_o[i], data_o[i], done_o[i], busy_o[i]}), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < ND; i++)
         check($sformatf("post_reset_d%0d", i),
               64'({valid_o[i], data_o[i], done_o[i], busy_o[i], ready_o[i]}), 64'b00001);

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].d, vecs[i].adr, vecs[i].dat, 1'b0, '0, '0, r);
         check($sformatf("done_at_vec%0d", i), 64'(r.done_c - r.acc_cyc), 64'(vecs[i].exp_done));
      end

      // Back-to-back with a gap, then with no gap
      for (int d = 1; d <= 2; d++) begin
         send_frame(d, 32'h0000_0010, 32'h1111_2222, 1'b1, 32'h0000_0020, 32'h3333_4444, r1);
         send_frame(d, 32'h0000_0020, 32'h3333_4444, 1'b0, '0, '0, r2);
         check($sformatf("b2b_accept_after_done_d%0d", d), 64'(r2.acc_cyc - r1.done_c),
               64'(gap_of(d)));
         check($sformatf("b2b_strobe_spacing_d%0d", d), 64'(r2.first_s - r1.last_s),
               64'(bd_of(d) + gap_of(d) + 1));
      end

      // Reset while bit 20 is on the wire
      adr_in[0] = 32'h1234_5678;
      dat_in[0] = 32'h0F0F_0F0F;
      vld_in[0] = 1'b1;
      check("rst_pre_ready", 64'(ready_o[0]), 64'd1);
      @(negedge clk);
      vld_in[0] = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_bit20", 64'({valid_o[0], data_o[0]}), 64'b11);
      rst_n = 1'b0;
      vld_in[0] = 1'b1;
      adr_in[0] = $urandom;
      repeat (3) begin
         @(negedge clk);
         check("rst_abort_outs", 64'({valid_o[0], data_o[0], done_o[0], busy_o[0]}), 64'd0);
      end
      vld_in[0] = 1'b0;
      rst_n = 1'b1;
      quiet = 0;
      repeat (70) begin
         @(negedge clk);
         quiet += int'(valid_o[0]) + int'(data_o[0]) + int'(done_o[0]) + int'(busy_o[0]);
      end
      check("rst_quiet_after_abort", 64'(quiet), 64'd0);
      send_frame(0, 32'hCAFE_0000, 32'h0000_BEEF, 1'b0, '0, '0, r);

      // Random commands, sometimes held valid for back-to-back transfer
      d_rand = $urandom_range(0, 2);
      ra = $urandom;
      rd = $urandom;
      for (int i = 0; i < 12; i++) begin
         hold = (i < 11) && ($urandom_range(0, 1) == 1);
         na = $urandom;
         nd = $urandom;
         send_frame(d_rand, ra, rd, hold, na, nd, r);
         check($sformatf("rand%0d_done_at", i), 64'(r.done_c - r.acc_cyc),
               64'(64 * bd_of(d_rand) + 1));
         if (hold) begin
            ra = na;
            rd = nd;
         end else begin
            d_rand = $urandom_range(0, 2);
            ra = $urandom;
            rd = $urandom;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
